// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Galois LFSR pattern generator
// and its receive-side checker (taps 8,6,5,4).
package lfsr_pkg;

  localparam int LFSR_W = 8;

  // Bits that pick up r[0] after the right rotate.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'h38;

  typedef enum logic [1:0] {
    ST_SEEK,
    ST_VERIFY,
    ST_LOCKED
  } chk_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] r
  );
    return {r[0], r[LFSR_W-1:1]} ^ ({LFSR_W{r[0]}} & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR advance.
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] i_r,
  output logic [LFSR_W-1:0] o_next
);

  assign o_next = lfsr_next(i_r);

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR stream checker: seeds from the data,
// flywheels the expected sequence, and counts mismatches once locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [LFSR_W-1:0] i_data,
  input  logic              i_clear,
  output logic              o_locked,
  output logic              o_err,
  output logic [ERR_W-1:0]  o_err_count,
  output logic [LFSR_W-1:0] o_expected
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  chk_state_t        r_state;
  logic [LFSR_W-1:0] r_exp;
  logic [MW-1:0]     r_match;
  logic [LW-1:0]     r_miss;
  logic              r_locked;
  logic              r_err;
  logic [ERR_W-1:0]  r_cnt;

  logic              w_hit;
  logic              w_seed;
  logic [LFSR_W-1:0] w_step_in;
  logic [LFSR_W-1:0] w_next;
  logic [MW-1:0]     w_match_inc;
  logic [LW-1:0]     w_miss_inc;
  logic              w_cnt_max;

  assign w_hit       = (i_data == r_exp);
  assign w_match_inc = r_match + MW'(1);
  assign w_miss_inc  = r_miss + LW'(1);
  assign w_cnt_max   = &r_cnt;

  // Outside lock, any byte that is not the expected one reseeds.
  assign w_seed    = (r_state != ST_LOCKED) &&
                     !((r_state == ST_VERIFY) && w_hit);
  assign w_step_in = w_seed ? i_data : r_exp;

  lfsr_step u_step (
    .i_r    (w_step_in),
    .o_next (w_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_SEEK;
      r_exp    <= '0;
      r_match  <= '0;
      r_miss   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_err <= 1'b0;
      if (i_valid) begin
        unique case (r_state)
          ST_SEEK: begin
            if (i_data != '0) begin
              r_exp   <= w_next;
              r_match <= '0;
              r_state <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            r_exp <= w_next;
            if (w_hit) begin
              r_match <= w_match_inc;
              if (w_match_inc == MW'(LOCK_COUNT)) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_miss   <= '0;
              end
            end else begin
              r_match <= '0;
              if (i_data == '0) r_state <= ST_SEEK;
            end
          end
          ST_LOCKED: begin
            r_exp <= w_next;
            if (w_hit) begin
              r_miss <= '0;
            end else begin
              r_err  <= 1'b1;
              r_miss <= w_miss_inc;
              if (!w_cnt_max) r_cnt <= r_cnt + ERR_W'(1);
              if (w_miss_inc == LW'(LOSS_COUNT)) begin
                r_state  <= ST_SEEK;
                r_locked <= 1'b0;
                r_miss   <= '0;
              end
            end
          end
          default: r_state <= ST_SEEK;
        endcase
      end
      if (i_clear) r_cnt <= '0;
    end
  end

  assign o_locked    = r_locked;
  assign o_err       = r_err;
  assign o_err_count = r_cnt;
  assign o_expected  = r_exp;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed plus randomised bench for lfsr_checker, two parameter sets
// sharing one stimulus stream against a behavioural reference.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = '0;
  logic       i_clear = 1'b0;

  logic        lk0, er0, lk1, er1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  logic [7:0]  ex0, ex1;

  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(16)) dut0 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid),
    .i_data(i_data), .i_clear(i_clear),
    .o_locked(lk0), .o_err(er0), .o_err_count(cnt0),
    .o_expected(ex0)
  );

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(8), .ERR_W(2)) dut1 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid),
    .i_data(i_data), .i_clear(i_clear),
    .o_locked(lk1), .o_err(er1), .o_err_count(cnt1),
    .o_expected(ex1)
  );

  // Reference: phase 0 hunting, 1 confirming, 2 tracking.
  int       m_phase[2];
  bit [7:0] m_exp[2];
  int       m_good[2];
  int       m_bad[2];
  int       m_cnt[2];
  bit       m_err[2];
  int       m_loss[2] = '{3, 8};
  int       m_max[2]  = '{65535, 3};

  bit [7:0] g;

  function automatic bit [7:0] nx(input bit [7:0] x);
    return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0;
      if (i_reset) begin
        m_phase[k] = 0; m_exp[k] = 8'h00;
        m_good[k] = 0; m_bad[k] = 0; m_cnt[k] = 0;
        continue;
      end
      if (i_valid) begin
        if (m_phase[k] == 0) begin
          if (i_data != 8'h00) begin
            m_exp[k] = nx(i_data); m_good[k] = 0; m_phase[k] = 1;
          end
        end else if (m_phase[k] == 1) begin
          if (i_data == m_exp[k]) begin
            m_good[k]++;
            m_exp[k] = nx(m_exp[k]);
            if (m_good[k] == 4) begin
              m_phase[k] = 2; m_bad[k] = 0;
            end
          end else begin
            m_exp[k] = nx(i_data); m_good[k] = 0;
            if (i_data == 8'h00) m_phase[k] = 0;
          end
        end else begin
          if (i_data == m_exp[k]) m_bad[k] = 0;
          else begin
            m_err[k] = 1'b1;
            if (m_cnt[k] < m_max[k]) m_cnt[k]++;
            m_bad[k]++;
            if (m_bad[k] == m_loss[k]) m_phase[k] = 0;
          end
          m_exp[k] = nx(m_exp[k]);
        end
      end
      if (i_clear) m_cnt[k] = 0;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("locked0", int'(lk0), int'(m_phase[0] == 2));
    chk("err0", int'(er0), int'(m_err[0]));
    chk("count0", int'(cnt0), m_cnt[0]);
    chk("expected0", int'(ex0), int'(m_exp[0]));
    chk("locked1", int'(lk1), int'(m_phase[1] == 2));
    chk("err1", int'(er1), int'(m_err[1]));
    chk("count1", int'(cnt1), m_cnt[1]);
    chk("expected1", int'(ex1), int'(m_exp[1]));
  endtask

  task automatic step(input bit v, input bit [7:0] d, input bit c);
    i_valid = v; i_data = d; i_clear = c;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step(1'b1, 8'h5A, 1'b1);
    i_reset = 1'b0;
  endtask

  // Send the true stream byte and advance the generator.
  task automatic good_byte();
    step(1'b1, g, 1'b0);
    g = nx(g);
  endtask

  task automatic bad_byte(input bit [7:0] d, input bit c);
    step(1'b1, d, c);
    g = nx(g);
  endtask

  initial begin
    do_reset();
    chk("rst_locked", int'(lk0), 0);
    chk("rst_expected", int'(ex0), 0);
    chk("rst_count", int'(cnt0), 0);

    g = 8'h64;
    for (int i = 0; i < 4; i++) good_byte();
    chk("no_lock_4th", int'(lk0), 0);
    good_byte();
    chk("lock_5th", int'(lk0), 1);
    chk("exp_after_lock", int'(ex0), 8'h2D);
    chk("count_at_lock", int'(cnt0), 0);

    bad_byte(8'h00, 1'b0);
    chk("single_err_pulse", int'(er0), 1);
    for (int i = 0; i < 3; i++) good_byte();
    chk("single_err_count", int'(cnt0), 1);
    chk("single_err_locked", int'(lk0), 1);

    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 2; i++) bad_byte(~g, 1'b0);
    chk("loss_locked_2", int'(lk0), 1);
    bad_byte(~g, 1'b0);
    chk("loss_err_3", int'(er0), 1);
    chk("loss_count", int'(cnt0), 3);
    chk("loss_unlocked", int'(lk0), 0);
    for (int i = 0; i < 4; i++) good_byte();
    chk("relock_not_yet", int'(lk0), 0);
    good_byte();
    chk("relock", int'(lk0), 1);

    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) good_byte();
      else step(1'b0, 8'($urandom), 1'b0);
    end
    chk("toggle_locked", int'(lk0), 1);
    chk("toggle_count", int'(cnt0), 3);

    for (int i = 0; i < 300; i++) begin
      bit c;
      c = ($urandom % 32) == 0;
      if (($urandom % 3) == 0) step(1'b0, 8'($urandom), c);
      else if (($urandom % 6) == 0) begin
        if (($urandom % 4) == 0) bad_byte(8'h00, c);
        else bad_byte(g ^ (8'h01 << ($urandom % 8)), c);
      end else begin
        step(1'b1, g, c);
        g = nx(g);
      end
    end

    do_reset();
    g = 8'($urandom_range(1, 255));
    for (int i = 0; i < 6; i++) good_byte();
    bad_byte(~g, 1'b1);
    chk("clear_err_pulse", int'(er0), 1);
    chk("clear_wins", int'(cnt0), 0);
    good_byte();

    for (int i = 0; i < 5; i++) begin
      bad_byte(~g, 1'b0);
      good_byte();
    end
    chk("sat_count", int'(cnt1), 3);
    chk("sat_locked", int'(lk1), 1);
    chk("nosat_count", int'(cnt0), 5);

    do_reset();
    chk("rst_mid_locked", int'(lk1), 0);
    chk("rst_mid_count", int'(cnt1), 0);
    chk("rst_mid_exp", int'(ex1), 0);
    chk("rst_mid_err", int'(er1), 0);

    for (int i = 0; i < 10; i++) step(1'b1, 8'h00, 1'b0);
    chk("zero_locked", int'(lk0), 0);
    chk("zero_err", int'(er0), 0);
    chk("zero_exp", int'(ex0), 0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
